// File: rtl/serial_to_parallel.sv
// serial_to_parallel: gathers WIDTH qualified serial bits into one parallel word.
// The completed word is registered on dout_parallel, and dout_valid pulses for one cycle.
// Define S2P_LSB_FIRST_EN to make the first received bit land in dout_parallel[0].
// The default build is MSB-first: the first received bit lands in dout_parallel[WIDTH-1].
module serial_to_parallel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             din_serial,
   input  logic             din_valid,
   output logic [WIDTH-1:0] dout_parallel,
   output logic             dout_valid
);

   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic             done;

   // Next shift-register value if the current bit is taken; the bit order is selected at build time
`ifdef S2P_LSB_FIRST_EN
   assign shift_nxt = {din_serial, shift_q[WIDTH-1:1]};
`else
   assign shift_nxt = {shift_q[WIDTH-2:0], din_serial};
`endif

   // The word completes on the edge that takes its last bit
   assign done = din_valid && (cnt_q == LAST);

   // Shift and count only on qualified bits, so an idle din_serial never disturbs state.
   // The shift register is not cleared at completion because the next word overwrites every bit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         shift_q       <= '0;
         cnt_q         <= '0;
         dout_parallel <= '0;
         dout_valid    <= 1'b0;
      end else begin
         dout_valid <= done;
         if (din_valid) begin
            shift_q <= shift_nxt;
            cnt_q   <= done ? '0 : cnt_q + 1'b1;
         end
         if (done) dout_parallel <= shift_nxt;
      end
   end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Testbench for serial_to_parallel.
// A queue-based reference model predicts each word, and a negedge monitor compares the DUT against it.
// Define S2P_LSB_FIRST_EN here as well as in the design to check the LSB-first build.
module tb_serial_to_parallel;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         din_serial = 1'b0;
   logic         din_valid = 1'b0;
   logic [W-1:0] dout_parallel;
   logic         dout_valid;

   int total = 0;
   int bad   = 0;

   serial_to_parallel #(.WIDTH(W)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .din_serial    (din_serial),
      .din_valid     (din_valid),
      .dout_parallel (dout_parallel),
      .dout_valid    (dout_valid)
   );

   always #5 clk = ~clk;

   // Reference model state: bits of the word in progress, predicted words, and the expected held output
   bit           cur[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_hold = '0;
   bit           mon_en = 1'b0;
   bit           prev_valid = 1'b0;

   // Builds a word from the received bits: in arrival order, then placed by the configured bit order
   function automatic logic [W-1:0] assemble();
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
`ifdef S2P_LSB_FIRST_EN
         w[i] = cur[i];
`else
         w[W-1-i] = cur[i];
`endif
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, waits for the sampling edge, then updates the model
   task automatic step(input logic r, input logic v, input logic b);
      rstn = r; din_valid = v; din_serial = b;
      @(posedge clk);
      if (!r) begin
         cur.delete();
         exp_hold = '0;
      end else if (v) begin
         cur.push_back(b);
         if (cur.size() == W) begin
            exp_q.push_back(assemble());
            cur.delete();
         end
      end
      #1;
   endtask

   // Sends bits in the order they are written in s, with s[W-1] going first
   task automatic send_seq(input logic [W-1:0] s);
      for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b1, s[i]);
   endtask

   // Sends the bits so that the word w is the one that gets assembled
   task automatic send_word(input logic [W-1:0] w);
`ifdef S2P_LSB_FIRST_EN
      for (int i = 0; i < W; i++) step(1'b1, 1'b1, w[i]);
`else
      for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b1, w[i]);
`endif
   endtask

   // Monitor: checks each pulse against the prediction, rejects repeated pulses,
   // and checks that the output holds its value between pulses
   always @(negedge clk) begin
      if (mon_en) begin
         if (dout_valid) begin
            total++;
            if (prev_valid) begin
               bad++;
               $display("FAIL double_pulse: dout_valid=1 for 2 cycles, expected 1 at %0t", $time);
            end
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_pulse: word %h with no word expected at %0t", dout_parallel, $time);
            end else begin
               exp_hold = exp_q.pop_front();
               chk("word", dout_parallel, exp_hold);
            end
         end else begin
            chk("hold", dout_parallel, exp_hold);
            if (exp_q.size() != 0) begin
               total++; bad++;
               $display("FAIL missing_pulse: dout_valid=0, expected word %h at %0t", exp_q[0], $time);
               exp_hold = exp_q.pop_front();
            end
         end
         prev_valid = dout_valid;
      end
   end

   logic [W-1:0] e2, e4, e5;

   initial begin
`ifdef S2P_LSB_FIRST_EN
      e2 = 8'h0F; e4 = 8'h55; e5 = 8'h80;
`else
      e2 = 8'hF0; e4 = 8'hAA; e5 = 8'h01;
`endif
      // 1: reset for two cycles with no valid input
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("reset_dout", dout_parallel, 8'h00);
      chk("reset_valid", {7'd0, dout_valid}, 8'h00);
      mon_en = 1'b1;

      // 2: first word
      send_seq(8'b1111_0000);
      chk("t2_word", dout_parallel, e2);

      // 3: idle for three cycles, then a second word
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      chk("t3_idle_hold", dout_parallel, e2);
      send_seq(8'b1100_0011);
      chk("t3_word", dout_parallel, 8'hC3);

      // 4: gap in the middle of a word while din_serial toggles
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ~i[0]);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i[0]);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ~i[0]);
      chk("t4_gap_word", dout_parallel, e4);

      // 5: reset in the middle of a word discards the partial bits
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("t5_reset_clear", dout_parallel, 8'h00);
      send_seq(8'b0000_0001);
      chk("t5_word", dout_parallel, e5);

      // 6: two words back to back
      send_word(8'hA5);
      chk("t6_first", dout_parallel, 8'hA5);
      send_word(8'h3C);
      chk("t6_second", dout_parallel, 8'h3C);

      // Random traffic with random gaps and occasional resets
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) == 0) step(1'b0, 1'(($urandom_range(0, 1))), 1'($urandom_range(0, 1)));
         else step(1'b1, 1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 1)));
      end

      // Drain: let the monitor see any final pulse
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d words still expected, expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
